// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: state encoding,
// default widths and the word-alignment check.
package mem_access_stage_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_REGADDR_W = 5;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic addr_misaligned(input logic [1:0] addr_lo);
    return (addr_lo & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_stage_pipe_reg.sv
// Parameterised pipeline register with asynchronous reset, load enable and
// bubble-clear. Bubble-clear zeroes only the bits selected by CLR_MASK and
// holds the rest; it takes priority over the load enable.
module pipe_reg #(
  parameter int unsigned    W        = 1,
  parameter logic [W-1:0]   CLR_MASK = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // Next value: bubble, load, or hold.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = q_q & ~CLR_MASK;
    end else if (en) begin
      q_d = d;
    end
  end

  // Register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, data-memory
// req/ready access FSM, stall generation and the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned REGADDR_W = DEF_REGADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     aluout_exe,
  input  logic [WIDTH-1:0]     writedata_exe,
  input  logic [REGADDR_W-1:0] regaddr_exe,
  input  logic                 regwrite_exe,
  input  logic                 memread_exe,
  input  logic                 memwrite_exe,
  input  logic                 memtoreg_exe,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [WIDTH-1:0]     dmem_addr,
  output logic [WIDTH-1:0]     dmem_wdata,
  input  logic [WIDTH-1:0]     dmem_rdata,
  input  logic                 dmem_ready,
  output logic                 stall_mem,
  output logic                 misalign_mem,
  output logic [WIDTH-1:0]     aluout_mem,
  output logic [REGADDR_W-1:0] regaddr_mem,
  output logic                 regwrite_mem,
  output logic [WIDTH-1:0]     result_wb,
  output logic [REGADDR_W-1:0] regaddr_wb,
  output logic                 regwrite_wb
);

  localparam int unsigned EXMEM_W = 2 * WIDTH + REGADDR_W + 3;
  localparam int unsigned MEMWB_W = WIDTH + REGADDR_W + 1;

  mem_state_e state_d, state_q;
  logic       misalign_d, misalign_q;

  logic memop_exe;
  logic misalign_exe;
  logic valid_memop_exe;

  logic [EXMEM_W-1:0] exmem_d, exmem_q;
  logic [MEMWB_W-1:0] memwb_d, memwb_q;

  logic [WIDTH-1:0] wdata_mem;
  logic             memwrite_mem;
  logic             memtoreg_mem;

  assign memop_exe       = memread_exe | memwrite_exe;
  assign misalign_exe    = memop_exe && addr_misaligned(aluout_exe[1:0]);
  assign valid_memop_exe = memop_exe && !misalign_exe;

  // memread is not kept in EX/MEM: a valid op is either a store (memwrite)
  // or a load, and the FSM has already decided to access at load time.
  // A misaligned entry enters with memwrite and regwrite cleared.
  assign exmem_d = {aluout_exe, writedata_exe, regaddr_exe,
                    regwrite_exe & ~misalign_exe,
                    memwrite_exe & ~misalign_exe,
                    memtoreg_exe};

  pipe_reg #(
    .W        (EXMEM_W),
    .CLR_MASK ('0)
  ) u_exmem (
    .clk (clk),
    .rst (rst),
    .en  (!stall_mem),
    .clr (1'b0),
    .d   (exmem_d),
    .q   (exmem_q)
  );

  assign {aluout_mem, wdata_mem, regaddr_mem, regwrite_mem,
          memwrite_mem, memtoreg_mem} = exmem_q;

  // Next state; stays in ACCESS when a new memory op loads on the completing edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MEM_IDLE:   if (valid_memop_exe) state_d = MEM_ACCESS;
      MEM_ACCESS: if (dmem_ready && !valid_memop_exe) state_d = MEM_IDLE;
      default:    state_d = MEM_IDLE;
    endcase
  end

  // Misalignment pulse is raised only when the offending entry actually loads.
  always_comb begin
    misalign_d = !stall_mem && misalign_exe;
  end

  // State and misalignment pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MEM_IDLE;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  assign dmem_req     = (state_q == MEM_ACCESS);
  assign stall_mem    = (state_q == MEM_ACCESS) && !dmem_ready;
  assign dmem_we      = memwrite_mem;
  assign dmem_addr    = aluout_mem;
  assign dmem_wdata   = wdata_mem;
  assign misalign_mem = misalign_q;

  // Stores never write the register file.
  assign memwb_d = {memtoreg_mem ? dmem_rdata : aluout_mem,
                    regaddr_mem,
                    regwrite_mem & ~memwrite_mem};

  pipe_reg #(
    .W        (MEMWB_W),
    .CLR_MASK (MEMWB_W'(1))
  ) u_memwb (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (stall_mem),
    .d   (memwb_d),
    .q   (memwb_q)
  );

  assign {result_wb, regaddr_wb, regwrite_wb} = memwb_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for the MEM pipeline stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aluout_exe, writedata_exe, dmem_rdata;
  logic [4:0]  regaddr_exe;
  logic        regwrite_exe, memread_exe, memwrite_exe, memtoreg_exe, dmem_ready;
  logic        dmem_req, dmem_we, stall_mem, misalign_mem, regwrite_mem, regwrite_wb;
  logic [31:0] dmem_addr, dmem_wdata, aluout_mem, result_wb;
  logic [4:0]  regaddr_mem, regaddr_wb;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  mem_access_stage #(.WIDTH(32), .REGADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .aluout_exe(aluout_exe), .writedata_exe(writedata_exe), .regaddr_exe(regaddr_exe),
    .regwrite_exe(regwrite_exe), .memread_exe(memread_exe), .memwrite_exe(memwrite_exe),
    .memtoreg_exe(memtoreg_exe),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_mem(stall_mem), .misalign_mem(misalign_mem),
    .aluout_mem(aluout_mem), .regaddr_mem(regaddr_mem), .regwrite_mem(regwrite_mem),
    .result_wb(result_wb), .regaddr_wb(regaddr_wb), .regwrite_wb(regwrite_wb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    aluout_exe = '0; writedata_exe = '0; regaddr_exe = '0;
    regwrite_exe = 0; memread_exe = 0; memwrite_exe = 0; memtoreg_exe = 0;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] ra,
                        input logic rw, input logic mr, input logic mw, input logic m2r);
    aluout_exe = a; writedata_exe = wd; regaddr_exe = ra;
    regwrite_exe = rw; memread_exe = mr; memwrite_exe = mw; memtoreg_exe = m2r;
  endtask

  task automatic test_reset();
    rst = 1; set_nop(); dmem_ready = 1; dmem_rdata = '0;
    #2;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", dmem_req); end
    n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall_mem); end
    n_cmp++; if (misalign_mem !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %b want 0", misalign_mem); end
    n_cmp++; if ({regwrite_mem, regwrite_wb} !== 2'b00) begin n_err++; $display("FAIL reset_regwrite got %b want 00", {regwrite_mem, regwrite_wb}); end
    n_cmp++; if (result_wb !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", result_wb); end
    tick(); tick();
    @(negedge clk); rst = 0;
  endtask

  task automatic test_alu_pass();
    set_op(32'h10, 32'h0, 5'd8, 1, 0, 0, 0);
    tick();
    set_nop();
    n_cmp++; if (aluout_mem !== 32'h10) begin n_err++; $display("FAIL alu_aluout_mem got %h want 10", aluout_mem); end
    n_cmp++; if (regwrite_mem !== 1'b1) begin n_err++; $display("FAIL alu_regwrite_mem got %b want 1", regwrite_mem); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL alu_req1 got %b want 0", dmem_req); end
    tick();
    n_cmp++; if (result_wb !== 32'h10) begin n_err++; $display("FAIL alu_result_wb got %h want 10", result_wb); end
    n_cmp++; if (regaddr_wb !== 5'd8) begin n_err++; $display("FAIL alu_regaddr_wb got %0d want 8", regaddr_wb); end
    n_cmp++; if (regwrite_wb !== 1'b1) begin n_err++; $display("FAIL alu_regwrite_wb got %b want 1", regwrite_wb); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL alu_req2 got %b want 0", dmem_req); end
    tick();
  endtask

  task automatic test_load_zero_wait();
    dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
    set_op(32'h100, 32'h0, 5'd9, 1, 1, 0, 1);
    tick();
    set_nop();
    n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL ld0_req got %b want 1", dmem_req); end
    n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL ld0_stall got %b want 0", stall_mem); end
    n_cmp++; if ({dmem_we, dmem_addr} !== {1'b0, 32'h100}) begin n_err++; $display("FAIL ld0_addr got %b/%h want 0/100", dmem_we, dmem_addr); end
    tick();
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL ld0_req_done got %b want 0", dmem_req); end
    n_cmp++; if (result_wb !== 32'hDEADBEEF) begin n_err++; $display("FAIL ld0_result got %h want deadbeef", result_wb); end
    n_cmp++; if ({regaddr_wb, regwrite_wb} !== {5'd9, 1'b1}) begin n_err++; $display("FAIL ld0_wb got %0d/%b want 9/1", regaddr_wb, regwrite_wb); end
    tick();
  endtask

  task automatic test_load_wait3();
    stall_cnt = 0;
    dmem_ready = 0; dmem_rdata = 32'hCAFE0001;
    set_op(32'h104, 32'h0, 5'd10, 1, 1, 0, 1);
    tick();
    // New instruction presented during the stall must be held off.
    set_op(32'h55, 32'h0, 5'd3, 1, 0, 0, 0);
    if (stall_mem === 1'b1) stall_cnt++;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (stall_mem === 1'b1) stall_cnt++;
      n_cmp++; if (regwrite_wb !== 1'b0) begin n_err++; $display("FAIL ld3_bubble%0d got %b want 0", i, regwrite_wb); end
      n_cmp++; if (aluout_mem !== 32'h104) begin n_err++; $display("FAIL ld3_hold%0d got %h want 104", i, aluout_mem); end
    end
    tick();
    n_cmp++; if (regwrite_wb !== 1'b0) begin n_err++; $display("FAIL ld3_bubble2 got %b want 0", regwrite_wb); end
    dmem_ready = 1;
    #1;
    n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL ld3_stall_release got %b want 0", stall_mem); end
    n_cmp++; if (stall_cnt !== 3) begin n_err++; $display("FAIL ld3_stall_cycles got %0d want 3", stall_cnt); end
    tick();
    set_nop();
    n_cmp++; if (result_wb !== 32'hCAFE0001) begin n_err++; $display("FAIL ld3_result got %h want cafe0001", result_wb); end
    n_cmp++; if ({regaddr_wb, regwrite_wb} !== {5'd10, 1'b1}) begin n_err++; $display("FAIL ld3_wb got %0d/%b want 10/1", regaddr_wb, regwrite_wb); end
    n_cmp++; if ({aluout_mem, dmem_req} !== {32'h55, 1'b0}) begin n_err++; $display("FAIL ld3_next got %h/%b want 55/0", aluout_mem, dmem_req); end
    tick();
    n_cmp++; if ({result_wb, regaddr_wb} !== {32'h55, 5'd3}) begin n_err++; $display("FAIL ld3_next_wb got %h/%0d want 55/3", result_wb, regaddr_wb); end
  endtask

  task automatic test_store();
    dmem_ready = 1;
    set_op(32'h204, 32'h12345678, 5'd11, 1, 0, 1, 0);
    tick();
    set_nop();
    n_cmp++; if ({dmem_req, dmem_we} !== 2'b11) begin n_err++; $display("FAIL st_req_we got %b want 11", {dmem_req, dmem_we}); end
    n_cmp++; if (dmem_addr !== 32'h204) begin n_err++; $display("FAIL st_addr got %h want 204", dmem_addr); end
    n_cmp++; if (dmem_wdata !== 32'h12345678) begin n_err++; $display("FAIL st_wdata got %h want 12345678", dmem_wdata); end
    tick();
    n_cmp++; if (regwrite_wb !== 1'b0) begin n_err++; $display("FAIL st_regwrite_wb got %b want 0", regwrite_wb); end
    tick();
  endtask

  task automatic test_misaligned();
    dmem_ready = 1;
    set_op(32'h102, 32'h0, 5'd12, 1, 1, 0, 1);
    tick();
    set_nop();
    n_cmp++; if ({dmem_req, misalign_mem} !== 2'b01) begin n_err++; $display("FAIL mis_pulse got req/mis %b want 01", {dmem_req, misalign_mem}); end
    n_cmp++; if (regwrite_mem !== 1'b0) begin n_err++; $display("FAIL mis_regwrite_mem got %b want 0", regwrite_mem); end
    tick();
    n_cmp++; if ({dmem_req, misalign_mem} !== 2'b00) begin n_err++; $display("FAIL mis_end got req/mis %b want 00", {dmem_req, misalign_mem}); end
    n_cmp++; if (regwrite_wb !== 1'b0) begin n_err++; $display("FAIL mis_regwrite_wb got %b want 0", regwrite_wb); end
    tick();
  endtask

  task automatic test_back_to_back();
    dmem_ready = 1; dmem_rdata = 32'hA5A5_0010;
    set_op(32'h10, 32'h0, 5'd4, 1, 1, 0, 1);
    tick();
    set_op(32'h14, 32'hBEEF_0014, 5'd5, 1, 0, 1, 0);
    n_cmp++; if ({dmem_req, dmem_we, dmem_addr} !== {2'b10, 32'h10}) begin n_err++; $display("FAIL b2b_load got %b%b/%h want 10/10", dmem_req, dmem_we, dmem_addr); end
    tick();
    set_nop();
    n_cmp++; if ({dmem_req, dmem_we, dmem_addr} !== {2'b11, 32'h14}) begin n_err++; $display("FAIL b2b_store got %b%b/%h want 11/14", dmem_req, dmem_we, dmem_addr); end
    n_cmp++; if ({result_wb, regwrite_wb} !== {32'hA5A5_0010, 1'b1}) begin n_err++; $display("FAIL b2b_wb got %h/%b want a5a50010/1", result_wb, regwrite_wb); end
    tick();
    n_cmp++; if ({dmem_req, regwrite_wb} !== 2'b00) begin n_err++; $display("FAIL b2b_end got %b want 00", {dmem_req, regwrite_wb}); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    dmem_ready = 0; dmem_rdata = 32'h0;
    set_op(32'h200, 32'h0, 5'd13, 1, 1, 0, 1);
    tick();
    set_nop();
    tick();
    n_cmp++; if ({dmem_req, stall_mem} !== 2'b11) begin n_err++; $display("FAIL rsm_pre got %b want 11", {dmem_req, stall_mem}); end
    rst = 1;
    #1;
    n_cmp++; if ({dmem_req, stall_mem, dmem_we, regwrite_mem, regwrite_wb} !== 5'b0) begin n_err++; $display("FAIL rsm_ctrl got %b want 00000", {dmem_req, stall_mem, dmem_we, regwrite_mem, regwrite_wb}); end
    n_cmp++; if ({dmem_addr, aluout_mem, result_wb} !== 96'h0) begin n_err++; $display("FAIL rsm_data got %h/%h/%h want 0", dmem_addr, aluout_mem, result_wb); end
    @(negedge clk); rst = 0;
    dmem_ready = 1; dmem_rdata = 32'h0003_00AA;
    set_op(32'h300, 32'h0, 5'd14, 1, 1, 0, 1);
    tick();
    set_nop();
    n_cmp++; if ({dmem_req, stall_mem, dmem_addr} !== {2'b10, 32'h300}) begin n_err++; $display("FAIL rsm_new_req got %b%b/%h want 10/300", dmem_req, stall_mem, dmem_addr); end
    tick();
    n_cmp++; if ({result_wb, regaddr_wb, regwrite_wb} !== {32'h0003_00AA, 5'd14, 1'b1}) begin n_err++; $display("FAIL rsm_new_wb got %h/%0d/%b want 000300aa/14/1", result_wb, regaddr_wb, regwrite_wb); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rsm_new_done got %b want 0", dmem_req); end
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_load_zero_wait();
    test_load_wait3();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
